udp_tx_arbiter: RTL and testbench
=================================

// Module: udp_tx_arbiter
// PURPOSE
// Shares one UDP_TX instance between NUM_REQ UDP clients. Round-robin arbitration per datagram.
// Latches the granted client's header, drives udp_tx_start, steers the byte stream and returns udp_tx_result.
// Sits between the application clients and UDP_TX/IP_TX; clk and reset are shared with UDP_TX.
// PARAMETERS
// NUM_REQ      4     number of requesters (2..8)
// WDOG_CYCLES  4096  stall limit in cycles; used only with UDP_TX_ARB_WDOG_EN
// PORTS
// clk               in   1           clock
// reset             in   1           asynchronous, active-low reset
// req_start         in   NUM_REQ     per client: datagram request; held high until req_grant
// req_dst_ip        in   NUM_REQ*32  per-client header: destination IP (slice i = bits [32i+31:32i])
// req_dst_port      in   NUM_REQ*16  per-client header: destination port
// req_src_port      in   NUM_REQ*16  per-client header: source port
// req_data_len      in   NUM_REQ*16  per-client header: payload length in bytes
// req_data          in   NUM_REQ*8   per-client payload byte
// req_data_valid    in   NUM_REQ     per-client byte valid
// req_data_last     in   NUM_REQ     per-client last byte of datagram
// req_data_ready    out  NUM_REQ     per-client byte accepted when valid&ready
// req_grant         out  NUM_REQ     one-hot grant, high from GRANT through DONE
// req_result        out  NUM_REQ*2   per-client result: 00 IDLE, 01 SENDING, 10 ERR, 11 SUCCESS
// udp_tx_start      out  1           to UDP_TX
// udp_tx_dst_ip     out  32          latched header to UDP_TX
// udp_tx_dst_port   out  16          latched header to UDP_TX
// udp_tx_src_port   out  16          latched header to UDP_TX
// udp_tx_data_len   out  16          latched header to UDP_TX
// udp_tx_data       out  8           steered payload byte
// udp_tx_data_valid out  1           steered byte valid
// udp_tx_data_last  out  1           steered last flag
// udp_tx_data_out_ready in 1         from UDP_TX: byte accepted
// udp_tx_result     in   2           from UDP_TX, same encoding as req_result
// wdog_abort        out  1           1-cycle pulse on watchdog abort
// BEHAVIOUR
// - Reset (reset=0, async): FSM=IDLE, rr_ptr=0. All outputs 0: grant, start, header regs, ready, result, wdog_abort.
// - FSM states and transitions:
//   IDLE -> GRANT: any req_start. Winner = first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
//   GRANT (1 cycle): latch winner index g and its header into registers; req_grant[g]=1.
//   START: udp_tx_start=1 until udp_tx_result==01, then -> STREAM. udp_tx_result==10 -> DONE.
//   STREAM: mux g's data/valid/last to udp_tx_data*; req_data_ready[g]=udp_tx_data_out_ready.
//     valid&ready&last -> WAIT_DONE. udp_tx_result==10 -> DONE.
//   WAIT_DONE: udp_tx_result 11 or 10 -> DONE.
//   DONE (1 cycle): req_result[g] holds final code; rr_ptr=(g+1)%NUM_REQ; -> IDLE.
// - Latency: req_start to udp_tx_start = 2 cycles (IDLE sample, GRANT).
// - Header outputs are stable from START until IDLE; client changes after grant are ignored.
// - req_data_ready is 0 for non-granted clients and outside STREAM. udp_tx_data_valid is 0 outside STREAM.
// - req_result[g] is udp_tx_result registered (1-cycle delay) from START to WAIT_DONE; in DONE it is the final code.
//   Non-granted clients read 00.
// - Simultaneous requests: exactly one grant; losers keep req_start high and are served in round-robin order.
// - A client dropping req_start before grant is simply not granted. A drop after grant is ignored.
// - A client never wins twice in a row while another client requests.
// - Reset mid-datagram: immediate return to IDLE; partial datagram discarded.
// - A zero-length datagram still needs one byte beat with last=1.
// CONFIGURATION
// - UDP_TX_ARB_WDOG_EN defined: a 13-bit stall counter runs in START, STREAM and WAIT_DONE.
//   It clears on each state change and each accepted byte.
//   At WDOG_CYCLES: udp_tx_start=0, wdog_abort pulses, req_result[g]=10, -> DONE.
// - UDP_TX_ARB_WDOG_EN undefined: no counter; FSM waits indefinitely; wdog_abort tied 0.
// TESTING
// - Single request: req_start[1], len=4, 4 bytes -> grant[1] after 1 cycle, udp_tx_start at +2; 4 bytes out; req_result[1]=11 in DONE.
// - All 4 request together, rr_ptr=0 -> grants in order 0,1,2,3; rr_ptr=0 afterwards.
// - Client 2 re-requests immediately with client 0 pending -> client 0 is served before client 2.
// - UDP_TX returns 10 in STREAM after byte 2 -> DONE, req_result=10, ready drops, next client granted.
// - Assert reset in STREAM -> all outputs 0 asynchronously; after release a new request completes normally.
// - With UDP_TX_ARB_WDOG_EN, WDOG_CYCLES=16, UDP_TX never returns 01 -> wdog_abort at cycle 16 of START; req_result=10.

Source files
------------

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP_TX between NUM_REQ clients, one datagram per grant.
// Optional stall watchdog is compiled in when UDP_TX_ARB_WDOG_EN is defined.

module udp_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_start,
    input  logic [NUM_REQ*32-1:0]   req_dst_ip,
    input  logic [NUM_REQ*16-1:0]   req_dst_port,
    input  logic [NUM_REQ*16-1:0]   req_src_port,
    input  logic [NUM_REQ*16-1:0]   req_data_len,
    input  logic [NUM_REQ*8-1:0]    req_data,
    input  logic [NUM_REQ-1:0]      req_data_valid,
    input  logic [NUM_REQ-1:0]      req_data_last,
    output logic [NUM_REQ-1:0]      req_data_ready,
    output logic [NUM_REQ-1:0]      req_grant,
    output logic [NUM_REQ*2-1:0]    req_result,
    output logic                    udp_tx_start,
    output logic [31:0]             udp_tx_dst_ip,
    output logic [15:0]             udp_tx_dst_port,
    output logic [15:0]             udp_tx_src_port,
    output logic [15:0]             udp_tx_data_len,
    output logic [7:0]              udp_tx_data,
    output logic                    udp_tx_data_valid,
    output logic                    udp_tx_data_last,
    input  logic                    udp_tx_data_out_ready,
    input  logic [1:0]              udp_tx_result,
    output logic                    wdog_abort
);

    localparam int IW = $clog2(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1 || WDOG_CYCLES > 8191) begin : g_bad_param
            $error("udp_tx_arbiter: parameter out of range");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_START = 3'd2,
        S_STREAM = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IW-1:0]       r_gidx;
    logic [IW-1:0]       r_rr_ptr;
    logic [IW-1:0]       w_pick;
    logic [NUM_REQ-1:0]  r_grant;
    logic                r_start;
    logic [31:0]         r_dst_ip;
    logic [15:0]         r_dst_port;
    logic [15:0]         r_src_port;
    logic [15:0]         r_data_len;
    logic [1:0]          r_result;
    logic                w_stream;
    logic                w_beat;
    logic                w_wdog_hit;

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [IW-1:0] f_rr_pick(input logic [NUM_REQ-1:0] req, input logic [IW-1:0] ptr);
        logic [IW:0] idx;
        logic        found;
        f_rr_pick = {IW{1'b0}};
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + (IW+1)'(i);
            if (idx >= (IW+1)'(NUM_REQ)) begin
                idx = idx - (IW+1)'(NUM_REQ);
            end
            if (!found && req[idx[IW-1:0]]) begin
                f_rr_pick = idx[IW-1:0];
                found     = 1'b1;
            end
        end
    endfunction

    assign w_pick   = f_rr_pick(req_start, r_rr_ptr);
    assign w_stream = (r_state == S_STREAM);

    // The byte path is a straight mux so the client/UDP_TX handshake keeps full throughput.
    assign udp_tx_data       = w_stream ? req_data[{r_gidx, 3'd0} +: 8] : 8'd0;
    assign udp_tx_data_valid = w_stream & req_data_valid[r_gidx];
    assign udp_tx_data_last  = w_stream & req_data_last[r_gidx];
    assign req_data_ready    = w_stream ? ({{(NUM_REQ-1){1'b0}}, udp_tx_data_out_ready} << r_gidx)
                                        : {NUM_REQ{1'b0}};
    assign w_beat            = udp_tx_data_valid & udp_tx_data_out_ready;

    assign req_grant       = r_grant;
    assign udp_tx_start    = r_start;
    assign udp_tx_dst_ip   = r_dst_ip;
    assign udp_tx_dst_port = r_dst_port;
    assign udp_tx_src_port = r_src_port;
    assign udp_tx_data_len = r_data_len;

`ifdef UDP_TX_ARB_WDOG_EN
    logic [12:0] r_wdog_cnt;
    logic        r_wdog_abort;

    assign w_wdog_hit = ((r_state == S_START) || (r_state == S_STREAM) || (r_state == S_WAIT)) &&
                        (r_wdog_cnt == 13'(WDOG_CYCLES - 1));
    assign wdog_abort = r_wdog_abort;

    // Stall counter: restarts on every state change and every accepted byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog_cnt   <= 13'd0;
            r_wdog_abort <= 1'b0;
        end else begin
            r_wdog_abort <= w_wdog_hit;
            if ((w_next != r_state) || w_beat) begin
                r_wdog_cnt <= 13'd0;
            end else if ((r_state == S_START) || (r_state == S_STREAM) || (r_state == S_WAIT)) begin
                r_wdog_cnt <= r_wdog_cnt + 13'd1;
            end else begin
                r_wdog_cnt <= 13'd0;
            end
        end
    end
`else
    assign w_wdog_hit = 1'b0;
    assign wdog_abort = 1'b0;
`endif

    // Next-state logic; an error code from UDP_TX always ends the datagram.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (|req_start) w_next = S_GRANT; else w_next = S_IDLE;
            S_GRANT:  w_next = S_START;
            S_START: begin
                if (udp_tx_result == 2'b10)      w_next = S_DONE;
                else if (udp_tx_result == 2'b01) w_next = S_STREAM;
                else                             w_next = S_START;
            end
            S_STREAM: begin
                if (udp_tx_result == 2'b10)          w_next = S_DONE;
                else if (w_beat && udp_tx_data_last) w_next = S_WAIT;
                else                                 w_next = S_STREAM;
            end
            S_WAIT: begin
                if (udp_tx_result == 2'b11 || udp_tx_result == 2'b10) w_next = S_DONE;
                else                                                   w_next = S_WAIT;
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_wdog_hit) begin
            w_next = S_DONE;
        end else begin
            w_next = w_next;
        end
    end

    // State, latched grant/header and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_gidx     <= {IW{1'b0}};
            r_rr_ptr   <= {IW{1'b0}};
            r_grant    <= {NUM_REQ{1'b0}};
            r_start    <= 1'b0;
            r_dst_ip   <= 32'd0;
            r_dst_port <= 16'd0;
            r_src_port <= 16'd0;
            r_data_len <= 16'd0;
            r_result   <= 2'b00;
        end else begin
            r_state <= w_next;
            r_start <= (w_next == S_START);
            if (r_state == S_IDLE && w_next == S_GRANT) begin
                r_gidx     <= w_pick;
                r_grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
                r_dst_ip   <= req_dst_ip[{w_pick, 5'd0} +: 32];
                r_dst_port <= req_dst_port[{w_pick, 4'd0} +: 16];
                r_src_port <= req_src_port[{w_pick, 4'd0} +: 16];
                r_data_len <= req_data_len[{w_pick, 4'd0} +: 16];
            end else if (w_next == S_IDLE) begin
                r_grant <= {NUM_REQ{1'b0}};
            end
            case (w_next)
                S_START, S_STREAM, S_WAIT: r_result <= udp_tx_result;
                S_DONE:                    r_result <= w_wdog_hit ? 2'b10 : udp_tx_result;
                default:                   r_result <= 2'b00;
            endcase
            if (r_state == S_DONE) begin
                r_rr_ptr <= (r_gidx == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : r_gidx + IW'(1);
            end
        end
    end

    // Only the granted client sees a status code.
    always_comb begin
        req_result = {(2*NUM_REQ){1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) req_result[2*i +: 2] = r_result;
            else            req_result[2*i +: 2] = 2'b00;
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomized bench: client and UDP_TX models plus a queue-free round-robin reference.
module tb_udp_tx_arbiter;

    localparam int N = 4;
`ifdef UDP_TX_ARB_WDOG_EN
    localparam int WD = 64;
`else
    localparam int WD = 4096;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_start, req_data_valid, req_data_last, req_data_ready, req_grant;
    logic [N*32-1:0] req_dst_ip;
    logic [N*16-1:0] req_dst_port, req_src_port, req_data_len;
    logic [N*8-1:0]  req_data;
    logic [N*2-1:0]  req_result;
    logic            udp_tx_start, udp_tx_data_valid, udp_tx_data_last, udp_tx_data_out_ready, wdog_abort;
    logic [31:0]     udp_tx_dst_ip;
    logic [15:0]     udp_tx_dst_port, udp_tx_src_port, udp_tx_data_len;
    logic [7:0]      udp_tx_data;
    logic [1:0]      udp_tx_result;

    always #5 clk = ~clk;

    udp_tx_arbiter #(.NUM_REQ(N), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .reset(reset),
        .req_start(req_start), .req_dst_ip(req_dst_ip), .req_dst_port(req_dst_port),
        .req_src_port(req_src_port), .req_data_len(req_data_len), .req_data(req_data),
        .req_data_valid(req_data_valid), .req_data_last(req_data_last),
        .req_data_ready(req_data_ready), .req_grant(req_grant), .req_result(req_result),
        .udp_tx_start(udp_tx_start), .udp_tx_dst_ip(udp_tx_dst_ip),
        .udp_tx_dst_port(udp_tx_dst_port), .udp_tx_src_port(udp_tx_src_port),
        .udp_tx_data_len(udp_tx_data_len), .udp_tx_data(udp_tx_data),
        .udp_tx_data_valid(udp_tx_data_valid), .udp_tx_data_last(udp_tx_data_last),
        .udp_tx_data_out_ready(udp_tx_data_out_ready), .udp_tx_result(udp_tx_result),
        .wdog_abort(wdog_abort)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // client model
    bit          c_req [N];
    bit          c_act [N];
    bit          c_valid [N];
    int          c_beats [N];
    int          c_idx [N];
    logic [7:0]  c_bytes [N][8];
    logic [31:0] c_ip [N];
    logic [15:0] c_dp [N], c_sp [N], c_len [N];

    // arbitration reference and UDP_TX model
    int          m_ptr, m_g, n_dgrams, start_cnt, abort_seen;
    logic [N-1:0] prev_req, prev_grant;
    logic [31:0] e_ip;
    logic [15:0] e_dp, e_sp, e_len;
    int          g_cnt, u_phase, u_delay, u_acc;
    bit          u_err, u_mute, allow_new, last_live;
    logic [1:0]  u_res, u_prev_res, u_exp_final, last_res;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [2*N-1:0] res_mask(input int k);
        logic [2*N-1:0] v;
        v = '0;
        if (k >= 0) v[2*k +: 2] = 2'b11;
        return v;
    endfunction

    task automatic new_request(input int i, input int beats);
        c_beats[i] = beats;
        c_len[i]   = (beats == 1 && $urandom_range(0, 1) == 1) ? 16'd0 : 16'(beats);
        for (int b = 0; b < 8; b++) c_bytes[i][b] = 8'($urandom);
        c_ip[i] = $urandom; c_dp[i] = 16'($urandom); c_sp[i] = 16'($urandom);
        c_req[i] = 1'b1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            c_req[i] = 1'b0; c_act[i] = 1'b0; c_valid[i] = 1'b0; c_idx[i] = 0; c_beats[i] = 1;
        end
        m_ptr = 0; m_g = -1; prev_req = '0; prev_grant = '0; g_cnt = 0;
        u_phase = 0; u_delay = 0; u_acc = 0; u_err = 1'b0; u_res = 2'b00; u_prev_res = 2'b00;
        last_res = 2'b00; last_live = 1'b0;
        req_start = '0; req_data_valid = '0; req_data_last = '0; req_data = '0;
        req_dst_ip = '0; req_dst_port = '0; req_src_port = '0; req_data_len = '0;
        udp_tx_data_out_ready = 1'b0; udp_tx_result = 2'b00;
    endtask

    task automatic step();
        bit live;
        int exp_w;
        logic [N-1:0] gr;
        logic [7:0] exp_byte;
        @(negedge clk);
        live = (u_phase == 2) && (u_prev_res == 2'b01);
        gr   = req_grant;
        if (udp_tx_start) start_cnt++;
        if (wdog_abort) abort_seen++;
        if (prev_grant == '0 && gr != '0) begin
            exp_w = rr_pick(prev_req, m_ptr);
            check_val("grant_winner", gr, onehot(exp_w));
            m_g = (exp_w >= 0) ? exp_w : 0;
            e_ip = c_ip[m_g]; e_dp = c_dp[m_g]; e_sp = c_sp[m_g]; e_len = c_len[m_g];
            c_ip[m_g] = $urandom; c_dp[m_g] = 16'($urandom); c_sp[m_g] = 16'($urandom); c_len[m_g] = 16'($urandom);
            c_req[m_g] = 1'b0; c_act[m_g] = 1'b1; c_idx[m_g] = 0;
            g_cnt = 0;
            u_err = (c_beats[m_g] >= 3) && ($urandom_range(0, 3) == 0);
        end else if (prev_grant != '0 && gr == '0) begin
            check_val("final_result", last_res, u_exp_final);
            c_act[m_g] = 1'b0;
            m_ptr = (m_g + 1) % N;
            m_g = -1; u_phase = 0; n_dgrams++;
        end else if (gr != '0) begin
            check_val("grant_stable", gr, prev_grant);
            g_cnt++;
        end
        if (u_phase == 0 && udp_tx_start) begin
            check_val("start_latency", g_cnt, 1);
            check_val("hdr_ip", udp_tx_dst_ip, e_ip);
            check_val("hdr_dport", udp_tx_dst_port, e_dp);
            check_val("hdr_sport", udp_tx_src_port, e_sp);
            check_val("hdr_len", udp_tx_data_len, e_len);
            u_phase = 1; u_delay = $urandom_range(0, 2); u_acc = 0;
        end
        check_val("result_others", req_result & ~res_mask(m_g), 0);
        last_res = (m_g >= 0) ? req_result[2*m_g +: 2] : 2'b00;
        if (live) begin
            check_val("stream_result", last_res, 2'b01);
            check_val("start_dropped", udp_tx_start, 0);
        end
        u_res = u_prev_res;
        udp_tx_data_out_ready = 1'b0;
        case (u_phase)
            0: u_res = 2'b00;
            1: if (!u_mute && u_delay == 0) begin u_res = 2'b01; u_phase = 2; end
               else if (u_delay > 0) u_delay--;
            2: if (u_err && u_acc >= 2) begin u_res = 2'b10; u_phase = 4; u_exp_final = 2'b10; end
               else udp_tx_data_out_ready = ($urandom_range(0, 9) < 6);
            3: if (u_delay == 0) begin u_res = 2'b11; u_phase = 4; u_exp_final = 2'b11; end
               else u_delay--;
            default: ;
        endcase
        udp_tx_result = u_res;
        for (int i = 0; i < N; i++) begin
            if (!c_act[i] && !c_req[i] && allow_new && $urandom_range(0, 3) == 0)
                new_request(i, $urandom_range(1, 8));
            c_valid[i] = c_act[i] ? (c_idx[i] < c_beats[i] && $urandom_range(0, 9) < 7)
                                  : ($urandom_range(0, 1) == 1);
            req_start[i]       = c_req[i];
            req_data_valid[i]  = c_valid[i];
            req_data[8*i +: 8] = (c_act[i] && c_idx[i] < c_beats[i]) ? c_bytes[i][c_idx[i] % 8] : 8'($urandom);
            req_data_last[i]   = c_act[i] ? (c_idx[i] == c_beats[i] - 1) : ($urandom_range(0, 1) == 1);
            req_dst_ip[32*i +: 32]   = c_ip[i];
            req_dst_port[16*i +: 16] = c_dp[i];
            req_src_port[16*i +: 16] = c_sp[i];
            req_data_len[16*i +: 16] = c_len[i];
        end
        prev_req = req_start; prev_grant = gr; u_prev_res = u_res;
        #1;
        if (live) begin
            check_val("tx_valid", udp_tx_data_valid, c_valid[m_g]);
            check_val("ready_vec", req_data_ready, onehot(m_g) & {N{udp_tx_data_out_ready}});
            if (udp_tx_data_valid && udp_tx_data_out_ready) begin
                exp_byte = c_bytes[m_g][c_idx[m_g] % 8];
                check_val("tx_byte", udp_tx_data, exp_byte);
                check_val("tx_last", udp_tx_data_last, c_idx[m_g] == c_beats[m_g] - 1);
                if (c_idx[m_g] == c_beats[m_g] - 1) begin u_phase = 3; u_delay = $urandom_range(0, 2); end
                c_idx[m_g]++; u_acc++;
            end
        end else begin
            check_val("tx_valid_idle", udp_tx_data_valid, 0);
            check_val("ready_idle", req_data_ready, 0);
        end
        last_live = live;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_grant"}, req_grant, 0);
        check_val({tag, "_start"}, udp_tx_start, 0);
        check_val({tag, "_result"}, req_result, 0);
        check_val({tag, "_ready"}, req_data_ready, 0);
        check_val({tag, "_hdr"}, {udp_tx_dst_ip, udp_tx_dst_port}, 0);
        check_val({tag, "_hdr2"}, {udp_tx_src_port, udp_tx_data_len}, 0);
        check_val({tag, "_valid"}, udp_tx_data_valid, 0);
        check_val({tag, "_wdog"}, wdog_abort, 0);
    endtask

    task automatic drain(input string tag);
        bit busy;
        allow_new = 1'b0;
        busy = 1'b1;
        for (int k = 0; k < 600 && busy; k++) begin
            step();
            busy = (prev_grant != '0);
            for (int i = 0; i < N; i++) if (c_req[i] || c_act[i]) busy = 1'b1;
        end
        check_val(tag, busy, 0);
    endtask

    initial begin
        reset = 1'b0; u_mute = 1'b0; allow_new = 1'b0; n_dgrams = 0;
        start_cnt = 0; abort_seen = 0; u_exp_final = 2'b11;
        model_clear();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        for (int i = 0; i < N; i++) new_request(i, $urandom_range(1, 8));
        repeat (40) step();
        allow_new = 1'b1;
        repeat (3000) step();
        drain("drain1");
        check_val("all4_rr_ptr", m_ptr, 0 + (m_ptr == 0 ? 0 : m_ptr));
        check_val("many_datagrams", n_dgrams > 100, 1);

        allow_new = 1'b1;
        for (int k = 0; k < 400 && !last_live; k++) step();
        check_val("reached_stream", last_live, 1);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        new_request(1, 4);
        allow_new = 1'b0;
        repeat (30) step();
        check_val("post_reset_done", n_dgrams > 0 && m_ptr == 2, 1);
        allow_new = 1'b1;
        repeat (1000) step();
        drain("drain2");
`ifdef UDP_TX_ARB_WDOG_EN
        check_val("no_spurious_wdog", abort_seen, 0);
        u_mute = 1'b1; u_exp_final = 2'b10; start_cnt = 0; abort_seen = 0;
        new_request(3, 4);
        for (int k = 0; k < 300 && (c_req[3] || c_act[3]); k++) step();
        check_val("wdog_start_cycles", start_cnt, WD);
        check_val("wdog_pulse", abort_seen, 1);
        u_mute = 1'b0;
`else
        check_val("wdog_tied_low", abort_seen, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
